// File: rtl/dct2_4_sched.sv
// Row scheduler for a shared combinational 4-point DCT-II core; a block is NROWS rows.
// Latency: 2 cycles from row acceptance to out_valid (stage-1 register, then 2-entry output FIFO).
// Backpressure: in_ready drops when the FIFO plus the in-flight stage-1 row would exceed 2 entries, and in DRAIN.
// Ports:
//   clk, rst_n           single clock, asynchronous active-low reset
//   in_valid/in_ready    input row handshake, in_data = {X3,X2,X1,X0}
//   core_x               registered row feeding the external core
//   core_ye/core_yo      core results {Ye1,Ye0} and {Yo1,Yo0}
//   out_valid/out_ready  output row handshake, out_data = {Y3,Y2,Y1,Y0}
//   out_row, out_last    row index within the block, last-row flag
//   busy                 FSM is not in IDLE
module dct2_4_sched #(
  parameter int NROWS = 4,
  parameter int W_IN  = 19,
  parameter int W_OUT = 27
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*W_IN-1:0]        in_data,
  output logic [4*W_IN-1:0]        core_x,
  input  logic [2*W_OUT-1:0]       core_ye,
  input  logic [2*W_OUT-1:0]       core_yo,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*W_OUT-1:0]       out_data,
  output logic [$clog2(NROWS)-1:0] out_row,
  output logic                     out_last,
  output logic                     busy
);

  localparam int RW = $clog2(NROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(NROWS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [RW-1:0]     in_cnt, in_cnt_nxt;
  logic [RW-1:0]     out_cnt;
  logic              s1_vld;
  logic [1:0]        fifo_cnt;
  logic              wr_ptr, rd_ptr;
  logic [4*W_OUT-1:0] mem [2];
  logic [4*W_OUT-1:0] core_res;
  logic              accept, push, pop;

  // Natural coefficient order: Y0=Ye0, Y1=Yo0, Y2=Ye1, Y3=Yo1.
  assign core_res = {core_yo[2*W_OUT-1:W_OUT], core_ye[2*W_OUT-1:W_OUT],
                     core_yo[W_OUT-1:0],       core_ye[W_OUT-1:0]};

  // The stage-1 row is counted as a reserved FIFO slot so a push can never hit a full FIFO.
  assign in_ready  = rst_n && (state == IDLE || state == LOAD) &&
                     (({1'b0, fifo_cnt} + {2'b00, s1_vld}) < 3'd2);
  assign accept    = in_valid && in_ready;
  assign push      = s1_vld;
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];
  assign out_row   = out_cnt;
  assign out_last  = out_valid && (out_cnt == LAST_ROW);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    in_cnt_nxt = in_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = LOAD;
          in_cnt_nxt = RW'(1);
        end
      end
      LOAD: begin
        if (accept) begin
          if (in_cnt == LAST_ROW) begin
            state_nxt  = DRAIN;
            in_cnt_nxt = '0;
          end else begin
            in_cnt_nxt = in_cnt + RW'(1);
          end
        end
      end
      DRAIN: begin
        if (pop && out_last) state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        in_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_cnt   <= '0;
      out_cnt  <= '0;
      s1_vld   <= 1'b0;
      core_x   <= '0;
      fifo_cnt <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      state  <= state_nxt;
      in_cnt <= in_cnt_nxt;
      s1_vld <= accept;
      if (accept) core_x <= in_data;
      if (push) begin
        mem[wr_ptr] <= core_res;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        out_cnt <= (out_cnt == LAST_ROW) ? '0 : out_cnt + RW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dct2_4_sched.sv
// Directed bench for dct2_4_sched with a behavioural 4-point DCT-II core and a scoreboard queue.
module tb_dct2_4_sched;

  localparam int NROWS = 4;
  localparam int W_IN  = 19;
  localparam int W_OUT = 27;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*W_IN-1:0]    in_data;
  logic [4*W_IN-1:0]    core_x;
  logic [2*W_OUT-1:0]   core_ye;
  logic [2*W_OUT-1:0]   core_yo;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*W_OUT-1:0]   out_data;
  logic [1:0]           out_row;
  logic                 out_last;
  logic                 busy;

  always #5 clk = ~clk;

  dct2_4_sched #(.NROWS(NROWS), .W_IN(W_IN), .W_OUT(W_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_x(core_x), .core_ye(core_ye), .core_yo(core_yo), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .busy(busy)
  );

  // Reference 4-point DCT-II (HEVC integer basis); result packed Y3..Y0, Y0 in LSBs.
  function automatic logic [3:0][W_OUT-1:0] dct4(input logic [4*W_IN-1:0] v);
    int x[4];
    int y[4];
    logic [3:0][W_OUT-1:0] r;
    for (int k = 0; k < 4; k++) x[k] = int'($signed(v[k*W_IN +: W_IN]));
    y[0] = 64 * (x[0] + x[1] + x[2] + x[3]);
    y[1] = 83 * (x[0] - x[3]) + 36 * (x[1] - x[2]);
    y[2] = 64 * (x[0] - x[1] - x[2] + x[3]);
    y[3] = 36 * (x[0] - x[3]) - 83 * (x[1] - x[2]);
    for (int k = 0; k < 4; k++) r[k] = W_OUT'(y[k]);
    return r;
  endfunction

  // Shared combinational core model
  logic [3:0][W_OUT-1:0] core_y;
  always_comb begin
    core_y  = dct4(core_x);
    core_ye = {core_y[2], core_y[0]};
    core_yo = {core_y[3], core_y[1]};
  end

  function automatic logic [4*W_IN-1:0] row4(input int a, input int b, input int c, input int d);
    return {d[W_IN-1:0], c[W_IN-1:0], b[W_IN-1:0], a[W_IN-1:0]};
  endfunction

  function automatic logic [4*W_IN-1:0] rnd_row();
    logic [4*W_IN-1:0] v;
    for (int k = 0; k < 4; k++) v[k*W_IN +: W_IN] = W_IN'($urandom);
    return v;
  endfunction

  typedef struct {
    logic [4*W_OUT-1:0] d;
    int                 row;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;
  int   exp_in_row;
  bit   acc;
  bit   busy_at_acc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, then advance to just past the rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        acc         = 1'b1;
        busy_at_acc = busy;
        q.push_back('{dct4(in_data), exp_in_row});
        exp_in_row  = (exp_in_row + 1) % NROWS;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_row", out_row, e.row);
          chk("out_last", out_last, e.row == NROWS - 1);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [4*W_IN-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain_idle();
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < 60) begin
      cyc();
      n++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_left", q.size(), 0);
  endtask

  task automatic drain_queue();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      cyc();
      n++;
    end
    chk("queue_left", q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_core_x"}, core_x, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_row"}, out_row, 0);
    chk({tag, "_out_last"}, out_last, 0);
  endtask

  initial begin
    logic [4*W_OUT-1:0] hold;
    int n_acc;
    checks     = 0;
    errors     = 0;
    exp_in_row = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;

    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", in_ready, 1);

    // Row of ones: DC only, 2-cycle latency
    in_valid = 1'b1;
    in_data  = row4(1, 1, 1, 1);
    cyc();
    chk("accept_ones", acc, 1);
    in_valid = 1'b0;
    chk("busy_load", busy, 1);
    chk("lat1_valid", out_valid, 0);
    cyc();
    chk("lat2_valid", out_valid, 1);
    chk("ones_data", out_data, {27'd0, 27'd0, 27'd0, 27'd256});

    // Impulse row, then two random rows complete the block
    send_row(row4(1, 0, 0, 0));
    in_valid = 1'b0;
    cyc();
    chk("impulse_data", out_data, {27'd36, 27'd64, 27'd83, 27'd64});
    send_row(rnd_row());
    send_row(rnd_row());
    in_valid = 1'b0;
    drain_idle();

    // Four streamed rows, fifth offered during DRAIN must wait for IDLE
    for (int i = 0; i < 4; i++) send_row(rnd_row());
    chk("drain_ready", in_ready, 0);
    chk("drain_busy_hi", busy, 1);
    send_row(row4(-5, 7, -9, 11));
    chk("fifth_after_idle", busy_at_acc, 0);
    in_valid = 1'b0;
    drain_queue();

    // Downstream stall: only 2 rows fit, output held stable
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = rnd_row();
    n_acc     = 0;
    repeat (8) begin
      cyc();
      if (acc) begin
        n_acc++;
        in_data = rnd_row();
      end
    end
    chk("stall_accepts", n_acc, 2);
    chk("stall_ready", in_ready, 0);
    chk("stall_valid", out_valid, 1);
    hold = out_data;
    cyc();
    chk("stall_hold", out_data, hold);
    out_ready = 1'b1;
    send_row(in_data);
    in_valid = 1'b0;
    drain_idle();

    // Reset in the middle of a block
    send_row(rnd_row());
    send_row(rnd_row());
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    q.delete();
    exp_in_row = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_row(rnd_row());
    in_valid = 1'b0;
    drain_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
